div_iter_hs: RTL and testbench
==============================

Name: div_iter_hs

Overview:
- Multi-cycle, fixed-latency integer divider with valid/ready handshakes on input and output.
- Successor to the single-step pipelined non-restoring divider stage.
- Adds signed (two's-complement) mode, final remainder correction, an iterative datapath reused over bits_per_cycle-bit steps, output back-pressure and a synchronous flush.
- Sits between the datapath issue logic and result writeback; one division in flight at a time.

Parameters:
- a_width, 32, dividend and quotient width; must be >= b_width.
- b_width, 32, divisor and remainder width; >= 2.
- bits_per_cycle, 4, quotient bits resolved per CALC cycle; a_width % bits_per_cycle must be 0, otherwise elaboration error.
- tc_mode, 0, 0 = unsigned operands and results; 1 = two's-complement.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous abort; returns the block to IDLE.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- dividend  in  a_width  dividend (numerator).
- divisor  in  b_width  divisor.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- quotient  out  a_width  quotient, truncated toward zero.
- remainder  out  b_width  remainder; takes the dividend's sign in tc_mode.
- div_by_0  out  1  divisor was zero for this result.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low. While reset is asserted: state = IDLE, in_ready = 0, out_valid = 0, quotient = 0, remainder = 0, div_by_0 = 0, and all internal registers are 0. in_ready rises the first cycle after rst_n deasserts.
- State machine: IDLE -> CALC -> FIX -> DONE -> IDLE.
  - IDLE: in_ready = 1. The operation is accepted on in_valid && in_ready. At acceptance:
    - capture operands; in tc_mode, capture absolute values and the signs sa and sb;
    - clear the partial remainder (b_width+1 bits) and load iteration counter = a_width/bits_per_cycle - 1;
    - capture dz = (divisor == 0);
    - go to CALC.
  - CALC: each cycle performs bits_per_cycle non-restoring steps:
    - add the divisor if the partial remainder is negative, subtract it if non-negative;
    - shift in the next dividend MSB;
    - each quotient bit = ~sign of the new partial remainder.
    - The counter decrements each cycle; at 0, go to FIX.
  - FIX: if the partial remainder is negative, add the divisor once. In tc_mode:
    - negate the quotient if sa^sb;
    - negate the remainder if sa.
    - Register quotient, remainder and div_by_0, then go to DONE.
  - DONE: out_valid = 1; outputs stay stable until out_valid && out_ready, then go to IDLE.
- Throughput and latency:
  - No overlap: in_ready = 0 outside IDLE, so a new operation can be accepted no earlier than the cycle after the result handshake.
  - Latency from the acceptance edge to out_valid high is a_width/bits_per_cycle + 1 cycles, and it is identical for every operand, including divide-by-zero.
- Divide by zero (dz = 1):
  - div_by_0 = 1.
  - Unsigned: quotient = all ones.
  - tc_mode: quotient = 0111..1 if dividend >= 0, 1000..0 if negative.
  - remainder = dividend[b_width-1:0].
  - div_by_0 = 0 for every non-zero divisor.
- Signed overflow (tc_mode, dividend = -2^(a_width-1), divisor = -1): quotient = -2^(a_width-1) (wraps), remainder = 0, div_by_0 = 0.
- Absolute value of the most negative operand is taken as an unsigned (width)-bit magnitude, with no overflow.
- flush:
  - Has priority over every state transition.
  - Next state = IDLE and out_valid = 0; registered outputs are not cleared.
  - A result pending in DONE is discarded.
  - flush together with in_valid in IDLE does not accept the operation.
- Reset mid-operation aborts immediately; no result is produced.
- Output stability: quotient, remainder and div_by_0 change only on the FIX -> DONE transition.
- in_valid, dividend and divisor are ignored outside IDLE.

Decomposition:
- Package div_pkg holds:
  - state enum div_state_t {IDLE, CALC, FIX, DONE};
  - function clog2 for the counter width;
  - constant functions for iteration count and correction width.
- Sub-module div_nr_step: combinational, parameters b_width and bits_per_cycle.
  - Inputs: partial remainder, divisor, dividend bits.
  - Outputs: new partial remainder, bits_per_cycle quotient bits, shifted dividend.
  - Instantiated once; the top module holds the FSM, counter, sign handling and output registers.

Test Plan:
- Unsigned, a_width = b_width = 32, bits_per_cycle = 4: 100/7 -> quotient 14, remainder 2, div_by_0 0; out_valid exactly 9 cycles after acceptance.
- tc_mode = 1: -100/7 -> quotient -14, remainder -2. 100/-7 -> 14... correction: quotient -14, remainder 2. -100/-7 -> quotient 14, remainder -2.
- Divide by zero: unsigned 0xDEADBEEF/0 -> quotient 0xFFFFFFFF, remainder 0xDEADBEEF, div_by_0 1. tc_mode -5/0 -> quotient 0x80000000, div_by_0 1; same latency as a normal divide.
- Signed overflow: 0x80000000 / 0xFFFFFFFF with tc_mode = 1 -> quotient 0x80000000, remainder 0. Also 0xFFFFFFFF/1 unsigned -> quotient 0xFFFFFFFF, remainder 0.
- Back-pressure: hold out_ready = 0 for 5 cycles in DONE -> outputs stable, in_ready = 0, and in_valid during those cycles is not accepted. Release -> in_ready = 1 on the next cycle.
- flush asserted in the 3rd CALC cycle, and separately in DONE -> IDLE next cycle, out_valid never asserted for the flushed operation. Assert rst_n = 0 mid-CALC -> all outputs 0 asynchronously; the next division after reset gives correct results.

Source files
------------

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and sizing helpers for the iterative divider
package div_pkg;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_t;

  function automatic int clog2(input int value);
    int res;
    int x;
    res = 0;
    x = value - 1;
    while (x > 0) begin
      res = res + 1;
      x = x >> 1;
    end
    return res;
  endfunction

  function automatic int iter_count(input int a_width, input int bits_per_cycle);
    return a_width / bits_per_cycle;
  endfunction

  function automatic int rem_width(input int b_width);
    return b_width + 1;
  endfunction

endpackage

// File: rtl/div_nr_step.sv
// rtl/div_nr_step.sv - bits_per_cycle unrolled non-restoring division steps
module div_nr_step #(
  parameter int a_width        = 32,
  parameter int b_width        = 32,
  parameter int bits_per_cycle = 4
) (
  input  logic [b_width:0]          rem_in,
  input  logic [b_width-1:0]        divisor,
  input  logic [a_width-1:0]        dvd_in,
  output logic [b_width:0]          rem_out,
  output logic [bits_per_cycle-1:0] q_bits,
  output logic [a_width-1:0]        dvd_out
);

  // The shift drops the old sign bit; the true result always fits b_width+1 bits,
  // so modular arithmetic on the truncated value is exact.
  always_comb begin
    logic [b_width:0] r;
    r      = rem_in;
    q_bits = '0;
    for (int i = 0; i < bits_per_cycle; i++) begin
      if (r[b_width])
        r = {r[b_width-1:0], dvd_in[a_width-1-i]} + {1'b0, divisor};
      else
        r = {r[b_width-1:0], dvd_in[a_width-1-i]} - {1'b0, divisor};
      q_bits[bits_per_cycle-1-i] = ~r[b_width];
    end
    rem_out = r;
  end

  assign dvd_out = dvd_in << bits_per_cycle;

endmodule

// File: rtl/div_iter_hs.sv
// rtl/div_iter_hs.sv - multi-cycle fixed-latency divider with valid/ready handshakes
module div_iter_hs
  import div_pkg::*;
#(
  parameter int a_width        = 32,
  parameter int b_width        = 32,
  parameter int bits_per_cycle = 4,
  parameter int tc_mode        = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [a_width-1:0] dividend,
  input  logic [b_width-1:0] divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [a_width-1:0] quotient,
  output logic [b_width-1:0] remainder,
  output logic               div_by_0
);

  localparam int iters = iter_count(a_width, bits_per_cycle);
  localparam int cnt_w = (clog2(iters) < 1) ? 1 : clog2(iters);
  localparam int rw    = rem_width(b_width);
  localparam bit tc    = (tc_mode != 0);
  localparam logic [cnt_w-1:0] cnt_last = cnt_w'(iters - 1);

  if (a_width % bits_per_cycle != 0) begin : g_bad_step
    $error("div_iter_hs: a_width must be a multiple of bits_per_cycle");
  end
  if (a_width < b_width || b_width < 2) begin : g_bad_width
    $error("div_iter_hs: need a_width >= b_width >= 2");
  end

  div_state_t         state, state_nxt;
  logic               run;
  logic [cnt_w-1:0]   cnt;
  logic [a_width-1:0] acc, acc_nxt, dvd_abs, q_res;
  logic [b_width-1:0] dvs, dvs_abs, dvd_lo, r_res;
  logic [rw-1:0]      prem, prem_nxt, rem_cor;
  logic [bits_per_cycle-1:0] q_bits;
  logic               sa, sb, dz, accept;

  assign accept  = in_valid && in_ready && !flush;
  assign dvd_abs = (tc && dividend[a_width-1]) ? -dividend : dividend;
  assign dvs_abs = (tc && divisor[b_width-1]) ? -divisor : divisor;

  div_nr_step #(
    .a_width(a_width), .b_width(b_width), .bits_per_cycle(bits_per_cycle)
  ) u_step (
    .rem_in(prem), .divisor(dvs), .dvd_in(acc),
    .rem_out(prem_nxt), .q_bits(q_bits), .dvd_out(acc_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = CALC;
      CALC: if (cnt == '0) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // run gates in_ready so it only rises on the first edge after reset release
  always_comb begin
    in_ready  = (state == IDLE) && run;
    out_valid = (state == DONE);
  end

  always_comb begin
    rem_cor = prem[b_width] ? prem + {1'b0, dvs} : prem;
    q_res   = (tc && (sa ^ sb)) ? -acc : acc;
    r_res   = (tc && sa) ? -rem_cor[b_width-1:0] : rem_cor[b_width-1:0];
    if (dz) begin
      if (tc) q_res = sa ? {1'b1, {(a_width-1){1'b0}}} : {1'b0, {(a_width-1){1'b1}}};
      else    q_res = '1;
      r_res = dvd_lo;
    end
  end

  // acc starts as the dividend magnitude and fills with quotient bits from the bottom
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run       <= 1'b0;
      cnt       <= '0;
      acc       <= '0;
      dvs       <= '0;
      dvd_lo    <= '0;
      prem      <= '0;
      sa        <= 1'b0;
      sb        <= 1'b0;
      dz        <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_by_0  <= 1'b0;
    end else begin
      run <= 1'b1;
      if (accept) begin
        acc    <= dvd_abs;
        dvs    <= dvs_abs;
        dvd_lo <= dividend[b_width-1:0];
        sa     <= tc && dividend[a_width-1];
        sb     <= tc && divisor[b_width-1];
        dz     <= (divisor == '0);
        prem   <= '0;
        cnt    <= cnt_last;
      end else if (state == CALC) begin
        prem <= prem_nxt;
        acc  <= acc_nxt | a_width'(q_bits);
        cnt  <= cnt - 1'b1;
      end
      if (state == FIX && !flush) begin
        quotient  <= q_res;
        remainder <= r_res;
        div_by_0  <= dz;
      end
    end
  end

endmodule

// File: tb/tb_div_iter_hs.sv
// tb/tb_div_iter_hs.sv - scoreboard bench driving unsigned and signed dividers in lockstep
module tb_div_iter_hs;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;

  logic u_in_ready, u_out_valid, u_div_by_0;
  logic s_in_ready, s_out_valid, s_div_by_0;
  logic [31:0] u_quotient, u_remainder, s_quotient, s_remainder;

  typedef struct {
    logic [31:0] uq, ur;
    logic        udz;
    logic [31:0] sq, sr;
    logic        sdz;
  } exp_t;

  exp_t sb_q[$];
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] last_uq = '0;

  always #5 clk = ~clk;

  div_iter_hs #(.a_width(32), .b_width(32), .bits_per_cycle(4), .tc_mode(0)) dut_u (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(u_in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(u_out_valid), .out_ready(out_ready),
    .quotient(u_quotient), .remainder(u_remainder), .div_by_0(u_div_by_0)
  );

  div_iter_hs #(.a_width(32), .b_width(32), .bits_per_cycle(4), .tc_mode(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(s_out_valid), .out_ready(out_ready),
    .quotient(s_quotient), .remainder(s_remainder), .div_by_0(s_div_by_0)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int sa_i, sb_i;
    if (b == 32'd0) begin
      e.uq = 32'hFFFF_FFFF; e.ur = a; e.udz = 1'b1;
      e.sq = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF; e.sr = a; e.sdz = 1'b1;
    end else begin
      e.uq = a / b; e.ur = a % b; e.udz = 1'b0; e.sdz = 1'b0;
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        e.sq = 32'h8000_0000; e.sr = 32'd0;
      end else begin
        sa_i = $signed(a);
        sb_i = $signed(b);
        e.sq = 32'(sa_i / sb_i);
        e.sr = 32'(sa_i % sb_i);
      end
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input int hold, input bit fl);
    int lat;
    exp_t e;
    logic [31:0] q0, r0;
    dividend = a; divisor = b; in_valid = 1'b1;
    sb_q.push_back(model(a, b));
    tick();
    in_valid = 1'b0; dividend = $urandom; divisor = $urandom;
    check("accept", {u_in_ready, s_in_ready}, 2'b00);
    lat = 0;
    while (!u_out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check("latency", lat, 9);
    check("s_valid", s_out_valid, 1'b1);
    q0 = u_quotient; r0 = s_remainder;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      tick();
      check("bp_valid", {u_out_valid, s_out_valid}, 2'b11);
      check("bp_ready", {u_in_ready, s_in_ready}, 2'b00);
      check("bp_stable", {u_quotient, s_remainder}, {q0, r0});
    end
    in_valid = 1'b0;
    e = sb_q.pop_front();
    check("u_quot", u_quotient, e.uq);
    check("u_rem", u_remainder, e.ur);
    check("u_dz", u_div_by_0, e.udz);
    check("s_quot", s_quotient, e.sq);
    check("s_rem", s_remainder, e.sr);
    check("s_dz", s_div_by_0, e.sdz);
    last_uq = e.uq;
    if (fl) flush = 1'b1;
    else    out_ready = 1'b1;
    tick();
    flush = 1'b0; out_ready = 1'b0;
    check("release", {u_out_valid, u_in_ready, s_out_valid, s_in_ready}, 4'b0101);
    if (fl) check("flush_keep", u_quotient, e.uq);
  endtask

  task automatic flush_calc(input logic [31:0] a, input logic [31:0] b);
    bit seen;
    dividend = a; divisor = b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_calc_idle", {u_in_ready, u_out_valid, s_in_ready, s_out_valid}, 4'b1010);
    check("flush_calc_keep", u_quotient, last_uq);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      seen = seen | u_out_valid | s_out_valid;
    end
    check("flush_calc_novalid", seen, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    #12;
    check("rst_hs", {u_in_ready, u_out_valid, s_in_ready, s_out_valid}, 4'b0000);
    check("rst_out", {u_quotient, u_remainder}, 64'd0);
    check("rst_dz", {u_div_by_0, s_div_by_0}, 2'b00);
    tick();
    rst_n = 1'b1;
    check("rdy_after_rst_0", u_in_ready, 1'b0);
    tick();
    check("rdy_after_rst_1", {u_in_ready, s_in_ready}, 2'b11);

    run_div(32'd100, 32'd7, 0, 1'b0);
    run_div(-32'sd100, 32'd7, 0, 1'b0);
    run_div(32'd100, -32'sd7, 0, 1'b0);
    run_div(-32'sd100, -32'sd7, 1, 1'b0);
    run_div(32'hDEAD_BEEF, 32'd0, 0, 1'b0);
    run_div(-32'sd5, 32'd0, 0, 1'b0);
    run_div(32'd5, 32'd0, 0, 1'b0);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    run_div(32'hFFFF_FFFF, 32'd1, 0, 1'b0);
    run_div(32'h1234_5678, 32'd3, 5, 1'b0);
    for (int i = 0; i < 8; i++)
      run_div($urandom, (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom,
              int'($urandom_range(0, 2)), 1'b0);

    flush_calc(32'd1000, 32'd9);
    run_div(32'd77, 32'd5, 0, 1'b1);

    flush = 1'b1; in_valid = 1'b1; dividend = 32'd50; divisor = 32'd5;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_idle_noacc", {u_in_ready, s_in_ready}, 2'b11);

    dividend = 32'd999; divisor = 32'd4; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_hs", {u_in_ready, u_out_valid, s_in_ready, s_out_valid}, 4'b0000);
    check("arst_out", {u_quotient, u_remainder}, 64'd0);
    check("arst_dz", {u_div_by_0, s_div_by_0}, 2'b00);
    tick();
    tick();
    rst_n = 1'b1;
    check("arst_rdy_0", u_in_ready, 1'b0);
    tick();
    check("arst_rdy_1", {u_in_ready, s_in_ready}, 2'b11);
    run_div(32'd100, 32'd7, 0, 1'b0);
    run_div(-32'sd2147483647, 32'd65536, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
